approx_err_monitor: RTL

Error-characterisation stage that sits directly downstream of the 8x8 approximate multipliers. It takes each operand pair together with the approximate product the multiplier produced, forms the exact product internally, and accumulates error-distance statistics over a programmed number of samples. It is used to qualify each multiplier configuration in hardware, and reports the sum of error distances, the maximum error distance, the count of erroneous samples and the count of over-estimates.

---
 rtl/approx_err_monitor_if.sv | 30 +++
 rtl/approx_err_monitor.sv | 108 ++++++++++
 2 files changed

// File: rtl/approx_err_monitor_if.sv
// Handshake and result bus of approx_err_monitor: sample stream in, run statistics out.
// master = sample/command source, slave = monitor.
interface approx_err_monitor_if #(
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
);
   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       a;
   logic [7:0]       b;
   logic [15:0]      r;
   logic             busy;
   logic             done;
   logic [SUM_W-1:0] sum_ed;
   logic [15:0]      max_ed;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] over_cnt;

   modport master (
      output start, num_samples, in_valid, a, b, r,
      input  in_ready, busy, done, sum_ed, max_ed, err_count, over_cnt
   );

   modport slave (
      input  start, num_samples, in_valid, a, b, r,
      output in_ready, busy, done, sum_ed, max_ed, err_count, over_cnt
   );
endinterface

// File: rtl/approx_err_monitor.sv
// Error-distance statistics for an 8x8 approximate multiplier over a programmed run of samples.
// Define ERR_MAX_TRACK_EN to track max_ed; otherwise max_ed is constant 0.
module approx_err_monitor #(
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
) (
   input  logic clk,
   input  logic rst,
   approx_err_monitor_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_target, r_acc_cnt;
   logic [1:0]       r_vld_pipe;
   logic [15:0]      r_s1_exact, r_s1_r, r_s2_ed;
   logic             r_s2_over;
   logic [SUM_W-1:0] r_sum;
   logic [CNT_W-1:0] r_err, r_over;
   logic             w_start_acc, w_accept, w_last, w_over;
   logic [15:0]      w_ed;
   logic [SUM_W:0]   w_sum_ext;

   assign w_accept  = (r_state == S_RUN) && bus.in_valid;
   assign w_last    = w_accept && (r_acc_cnt == r_target - 1'b1);
   assign w_over    = r_s1_r > r_s1_exact;
   assign w_ed      = w_over ? (r_s1_r - r_s1_exact) : (r_s1_exact - r_s1_r);
   assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(r_s2_ed);

   always_comb begin
      w_next      = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start) begin
            w_start_acc = 1'b1;
            w_next      = (bus.num_samples == '0) ? S_DONE : S_RUN;
         end
         S_RUN:   if (w_last) w_next = S_DRAIN;
         // last sample leaves stage 2 on the same edge we enter DONE
         S_DRAIN: if (!r_vld_pipe[0]) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_target   <= '0;
         r_acc_cnt  <= '0;
         r_vld_pipe <= '0;
         r_s1_exact <= '0;
         r_s1_r     <= '0;
         r_s2_ed    <= '0;
         r_s2_over  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_vld_pipe <= {r_vld_pipe[0], w_accept};
         if (w_start_acc) begin
            r_target  <= bus.num_samples;
            r_acc_cnt <= '0;
         end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
         end
         if (w_accept) begin
            r_s1_exact <= 16'(bus.a) * 16'(bus.b);
            r_s1_r     <= bus.r;
         end
         r_s2_ed   <= w_ed;
         r_s2_over <= w_over;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum  <= '0;
         r_err  <= '0;
         r_over <= '0;
      end else if (w_start_acc) begin
         r_sum  <= '0;
         r_err  <= '0;
         r_over <= '0;
      end else if (r_vld_pipe[1]) begin
         r_sum <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
         if (r_s2_ed != 16'd0) r_err  <= r_err + 1'b1;
         if (r_s2_over)        r_over <= r_over + 1'b1;
      end
   end

`ifdef ERR_MAX_TRACK_EN
   logic [15:0] r_max;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       r_max <= '0;
      else if (w_start_acc)                          r_max <= '0;
      else if (r_vld_pipe[1] && (r_s2_ed > r_max))   r_max <= r_s2_ed;
   end
   assign bus.max_ed = r_max;
`else
   assign bus.max_ed = 16'd0;
`endif

   assign bus.in_ready  = (r_state == S_RUN);
   assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign bus.done      = (r_state == S_DONE);
   assign bus.sum_ed    = r_sum;
   assign bus.err_count = r_err;
   assign bus.over_cnt  = r_over;
endmodule
